// File: rtl/hpi_pkg.sv
// Shared types and constants for the HPI bus master.
//   hpi_state_e : sequencing states of one HPI bus cycle
//   HPI_*       : HPI register select encodings on otg_addr
//   CNT_W       : width of the shared phase down-counter
//   cnt_load()  : counter reload value for a phase of a given length
package hpi_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StStrobe,
    StHold,
    StDone,
    StRecover
  } hpi_state_e;

  localparam logic [1:0] HPI_DATA    = 2'd0;
  localparam logic [1:0] HPI_MAILBOX = 2'd1;
  localparam logic [1:0] HPI_ADDRESS = 2'd2;
  localparam logic [1:0] HPI_STATUS  = 2'd3;

  localparam int unsigned CNT_W = 4;

  // The counter expires on zero, so a phase of N cycles loads N-1.
  // A zero-length phase (only legal for recovery) loads 0 and is skipped by the FSM.
  function automatic logic [CNT_W-1:0] cnt_load(input int unsigned cycles);
    if (cycles == 0) return '0;
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/hpi_irq_sync.sv
// Two-flop synchronizer for the asynchronous OTG interrupt pin.
//   clk      : system clock
//   reset    : asynchronous, active-high reset
//   async_in : asynchronous input (OTG interrupt pin, active low)
//   sync_out : input re-timed to clk, two edges of latency
// Flops reset to 1 so the synchronized pin reads as "no interrupt" during reset.
module hpi_irq_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic sync_out
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
    end
  end

  assign sync_out = sync_q;

endmodule

// File: rtl/hpi_bus_master.sv
// Avalon-MM slave that turns single 16-bit transfers into timed Cypress HPI bus cycles
// (setup, strobe, hold, recovery) on the OTG controller pins.
//
// Ports:
//   clk, reset                       : system clock, asynchronous active-high reset
//   address, chipselect, read, write : Avalon request (address selects the HPI register)
//   writedata, readdata, waitrequest : Avalon data and stall
//   otg_addr, otg_data_out/oe/in     : HPI address and data bus (tristate handled at top level)
//   otg_cs_n, otg_rd_n, otg_wr_n     : HPI chip select and strobes, active low
//   otg_int, irq                     : OTG interrupt pin in, CPU interrupt out
//
// Build option: define HPI_IRQ_SYNC_EN to synchronize and invert otg_int onto irq;
// otherwise irq is tied low and otg_int is ignored.
module hpi_bus_master
  import hpi_pkg::*;
#(
  parameter int unsigned SETUP_CYC   = 1,
  parameter int unsigned STROBE_CYC  = 4,
  parameter int unsigned HOLD_CYC    = 1,
  parameter int unsigned RECOVER_CYC = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        waitrequest,
  output logic [1:0]  otg_addr,
  output logic [15:0] otg_data_out,
  output logic        otg_data_oe,
  input  logic [15:0] otg_data_in,
  output logic        otg_cs_n,
  output logic        otg_rd_n,
  output logic        otg_wr_n,
  input  logic        otg_int,
  output logic        irq
);

  hpi_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             is_write_q;
  logic             req;
  logic             cnt_done;

  assign req      = chipselect & (read | write);
  assign cnt_done = (cnt_q == '0);

  // The only cycle an Avalon request is released is DONE; a request dropped
  // mid-cycle simply finds no one listening when DONE arrives.
  assign waitrequest = req & (state_q != StDone);

  // All pins are driven straight from flops; otg_data_out doubles as the write-data latch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      is_write_q   <= 1'b0;
      otg_addr     <= 2'd0;
      otg_data_out <= 16'd0;
      otg_data_oe  <= 1'b0;
      otg_cs_n     <= 1'b1;
      otg_rd_n     <= 1'b1;
      otg_wr_n     <= 1'b1;
      readdata     <= 16'd0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req) begin
            state_q     <= StSetup;
            cnt_q       <= cnt_load(SETUP_CYC);
            // write wins when read and write arrive together
            is_write_q  <= write;
            otg_addr    <= address;
            otg_cs_n    <= 1'b0;
            otg_data_oe <= write;
            if (write) otg_data_out <= writedata;
          end
        end
        StSetup: begin
          if (cnt_done) begin
            state_q  <= StStrobe;
            cnt_q    <= cnt_load(STROBE_CYC);
            otg_rd_n <= is_write_q;
            otg_wr_n <= ~is_write_q;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StStrobe: begin
          if (cnt_done) begin
            state_q  <= StHold;
            cnt_q    <= cnt_load(HOLD_CYC);
            otg_rd_n <= 1'b1;
            otg_wr_n <= 1'b1;
            // sample on the edge that closes the read strobe
            if (!is_write_q) readdata <= otg_data_in;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StHold: begin
          if (cnt_done) begin
            state_q     <= StDone;
            cnt_q       <= '0;
            otg_cs_n    <= 1'b1;
            otg_data_oe <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StDone: begin
          state_q <= (RECOVER_CYC == 0) ? StIdle : StRecover;
          cnt_q   <= cnt_load(RECOVER_CYC);
        end
        StRecover: begin
          if (cnt_done) begin
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef HPI_IRQ_SYNC_EN
  logic int_sync_n;

  hpi_irq_sync u_irq_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (otg_int),
    .sync_out (int_sync_n)
  );

  assign irq = ~int_sync_n;
`else
  logic unused_otg_int;
  assign unused_otg_int = otg_int;
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_hpi_bus_master.sv
module tb_hpi_bus_master;

  localparam int S = 1;
  localparam int P = 4;
  localparam int H = 1;
  localparam int R = 2;
`ifdef HPI_IRQ_SYNC_EN
  localparam logic IrqEn = 1'b1;
`else
  localparam logic IrqEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [15:0] writedata = 16'd0;
  logic [15:0] readdata;
  logic        waitrequest;
  logic [1:0]  otg_addr;
  logic [15:0] otg_data_out;
  logic        otg_data_oe;
  logic [15:0] otg_data_in = 16'hFFFF;
  logic        otg_cs_n;
  logic        otg_rd_n;
  logic        otg_wr_n;
  logic        otg_int = 1'b1;
  logic        irq;

  hpi_bus_master #(
    .SETUP_CYC   (S),
    .STROBE_CYC  (P),
    .HOLD_CYC    (H),
    .RECOVER_CYC (R)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .address      (address),
    .chipselect   (chipselect),
    .read         (read),
    .write        (write),
    .writedata    (writedata),
    .readdata     (readdata),
    .waitrequest  (waitrequest),
    .otg_addr     (otg_addr),
    .otg_data_out (otg_data_out),
    .otg_data_oe  (otg_data_oe),
    .otg_data_in  (otg_data_in),
    .otg_cs_n     (otg_cs_n),
    .otg_rd_n     (otg_rd_n),
    .otg_wr_n     (otg_wr_n),
    .otg_int      (otg_int),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  // cyc holds the index of the current clock cycle (bumped at every rising edge)
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected HPI pin cycle: direction, address, data and the cycle cs_n must fall in
  typedef struct {
    bit          wr;
    logic [1:0]  addr;
    logic [15:0] data;
    int          fall;
  } hpi_exp_t;

  hpi_exp_t    hpi_q[$];
  logic [15:0] av_q[$];

  // Reference model state: when the block can next accept, and what readdata should hold
  int          free = 0;
  logic [15:0] last_rdata = 16'd0;
  logic [15:0] dev_rdata = 16'd0;

  // HPI device: drives the bus with its read value while RD_N is low, floats (0xFFFF) otherwise
  always @(negedge clk) otg_data_in = otg_rd_n ? 16'hFFFF : dev_rdata;

  // Pin monitor: measures each cs_n-low window and checks it against the expected queue
  int          inv_bad = 0;
  bit          in_cyc = 0;
  int          len, rd_cnt, wr_cnt, first_strobe, start;
  logic [1:0]  a0;
  logic        oe0;
  logic [15:0] d0;
  bit          stable;

  always @(negedge clk) begin
    if (reset) begin
      in_cyc = 0;
    end else begin
      if ((!otg_rd_n && !otg_wr_n) || (otg_cs_n && (!otg_rd_n || !otg_wr_n || otg_data_oe)))
        inv_bad++;
      if (!otg_cs_n) begin
        if (!in_cyc) begin
          in_cyc = 1; len = 0; rd_cnt = 0; wr_cnt = 0; first_strobe = -1;
          start = cyc; a0 = otg_addr; oe0 = otg_data_oe; d0 = otg_data_out; stable = 1;
        end
        if (otg_addr != a0 || otg_data_oe != oe0 || (oe0 && otg_data_out != d0)) stable = 0;
        if (!otg_rd_n) rd_cnt++;
        if (!otg_wr_n) wr_cnt++;
        if ((!otg_rd_n || !otg_wr_n) && first_strobe < 0) first_strobe = len;
        len++;
      end else if (in_cyc) begin
        in_cyc = 0;
        check("hpi_cycle_expected", 32'(hpi_q.size() != 0), 32'd1);
        if (hpi_q.size() != 0) begin
          hpi_exp_t e;
          e = hpi_q.pop_front();
          check("cs_fall_cycle", 32'(start), 32'(e.fall));
          check("otg_addr", 32'(a0), 32'(e.addr));
          check("otg_data_oe", 32'(oe0), 32'(e.wr));
          if (e.wr) check("otg_data_out", 32'(d0), 32'(e.data));
          check("pins_stable", 32'(stable), 32'd1);
          check("cs_low_len", 32'(len), 32'(S + P + H));
          check("setup_len", 32'(first_strobe), 32'(S));
          check("strobe_len", 32'(e.wr ? wr_cnt : rd_cnt), 32'(P));
          check("other_strobe", 32'(e.wr ? rd_cnt : wr_cnt), 32'd0);
        end
      end
    end
  end

  // Avalon monitor: every released request pops one expected readdata value
  always @(negedge clk) begin
    if (!reset && chipselect && (read || write) && !waitrequest) begin
      check("av_response_expected", 32'(av_q.size() != 0), 32'd1);
      if (av_q.size() != 0) check("readdata", 32'(readdata), 32'(av_q.pop_front()));
    end
  end

  task automatic release_bus();
    @(posedge clk); #1;
    chipselect = 1'b0; read = 1'b0; write = 1'b0;
  endtask

  task automatic wait_free();
    while (cyc + 1 < free) begin
      @(posedge clk); #1;
    end
  endtask

  // One Avalon transfer held until accepted; the bus is left driven so the next
  // call can follow back-to-back.
  task automatic xfer(input bit do_rd, input bit do_wr, input logic [1:0] a,
                      input logic [15:0] wd, input logic [15:0] rv);
    int c0, s, d, n;
    hpi_exp_t e;
    @(posedge clk); #1;
    c0 = cyc;
    s = (c0 > free) ? c0 : free;
    d = s + 1 + S + P + H;
    free = d + 1 + R;
    e.wr = do_wr; e.addr = a; e.data = wd; e.fall = s + 1;
    hpi_q.push_back(e);
    if (!do_wr) begin
      dev_rdata = rv;
      last_rdata = rv;
    end
    av_q.push_back(last_rdata);
    chipselect = 1'b1; read = do_rd; write = do_wr; address = a; writedata = wd;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!waitrequest) break;
      n++;
    end
    check("wait_cycles", 32'(n), 32'(d - c0));
  endtask

  // Write dropped by the master after two cycles; the HPI cycle must still complete.
  task automatic abort_write(input logic [1:0] a, input logic [15:0] wd);
    hpi_exp_t e;
    @(posedge clk); #1;
    e.wr = 1'b1; e.addr = a; e.data = wd; e.fall = cyc + 1;
    free = cyc + 1 + S + P + H + 1 + R;
    hpi_q.push_back(e);
    chipselect = 1'b1; read = 1'b0; write = 1'b1; address = a; writedata = wd;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chipselect = 1'b0; write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int k, gap;
    logic [1:0] a;
    logic [15:0] wd;

    // Reset values
    #12;
    check("rst_cs_n", 32'(otg_cs_n), 32'd1);
    check("rst_rd_n", 32'(otg_rd_n), 32'd1);
    check("rst_wr_n", 32'(otg_wr_n), 32'd1);
    check("rst_oe", 32'(otg_data_oe), 32'd0);
    check("rst_addr", 32'(otg_addr), 32'd0);
    check("rst_data_out", 32'(otg_data_out), 32'd0);
    check("rst_readdata", 32'(readdata), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_waitrequest", 32'(waitrequest), 32'd0);
    @(posedge clk); #3;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Directed: write 0xBEEF to address 2, read 0x1234 from address 0
    xfer(1'b0, 1'b1, 2'd2, 16'hBEEF, 16'h0);
    release_bus();
    xfer(1'b1, 1'b0, 2'd0, 16'h0, 16'h1234);
    check("readdata_1234", 32'(readdata), 32'h1234);
    release_bus();
    repeat (3) @(posedge clk);
    #1;

    // Directed: two back-to-back writes, then read+write together at address 1
    xfer(1'b0, 1'b1, 2'd1, 16'h1111, 16'h0);
    xfer(1'b0, 1'b1, 2'd3, 16'h2222, 16'h0);
    release_bus();
    wait_free();
    xfer(1'b1, 1'b1, 2'd1, 16'h5A5A, 16'hDEAD);
    check("readdata_kept", 32'(readdata), 32'h1234);
    release_bus();
    wait_free();

    // Directed: reset in the middle of a write strobe
    @(posedge clk); #1;
    chipselect = 1'b1; write = 1'b1; address = 2'd3; writedata = 16'hA5A5;
    repeat (3) @(posedge clk);
    #2;
    check("wr_n_low_before_reset", 32'(otg_wr_n), 32'd0);
    #1;
    reset = 1'b1;
    #1;
    check("async_rst_wr_n", 32'(otg_wr_n), 32'd1);
    check("async_rst_cs_n", 32'(otg_cs_n), 32'd1);
    check("async_rst_oe", 32'(otg_data_oe), 32'd0);
    chipselect = 1'b0; write = 1'b0;
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    check("post_rst_waitrequest", 32'(waitrequest), 32'd0);
    check("post_rst_readdata", 32'(readdata), 32'd0);
    hpi_q.delete();
    av_q.delete();
    last_rdata = 16'd0;
    free = 0;

    // Interrupt path: two edges from pin to irq when synchronized, else always 0
    @(posedge clk); #1;
    otg_int = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("irq_after_1_edge", 32'(irq), 32'd0);
    @(negedge clk);
    check("irq_after_2_edges", 32'(irq), 32'(IrqEn));
    @(posedge clk); #1;
    otg_int = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("irq_release_1_edge", 32'(irq), 32'(IrqEn));
    @(negedge clk);
    check("irq_release_2_edges", 32'(irq), 32'd0);

    // A request that proves the block recovered from reset, then randomized traffic
    xfer(1'b1, 1'b0, 2'd2, 16'h0, 16'h0F0F);
    for (int it = 0; it < 40; it++) begin
      k = $urandom_range(0, 9);
      a = 2'($urandom_range(0, 3));
      wd = 16'($urandom);
      gap = $urandom_range(0, 3);
      if (k <= 3) begin
        xfer(1'b0, 1'b1, a, wd, 16'h0);
      end else if (k <= 6) begin
        xfer(1'b1, 1'b0, a, wd, 16'($urandom));
      end else if (k == 7) begin
        xfer(1'b1, 1'b1, a, wd, 16'($urandom));
      end else if (k == 8) begin
        release_bus();
        wait_free();
        abort_write(a, wd);
        wait_free();
      end else begin
        release_bus();
        @(posedge clk); #1;
        chipselect = 1'b0; read = 1'b1; write = 1'($urandom_range(0, 1)); address = a;
        @(negedge clk);
        check("noise_waitrequest", 32'(waitrequest), 32'd0);
        release_bus();
      end
      if (k <= 7 && gap > 0) begin
        release_bus();
        repeat (gap - 1) @(posedge clk);
        #1;
      end
    end
    release_bus();
    repeat (15) @(posedge clk);
    #1;

    check("hpi_queue_drained", 32'(hpi_q.size()), 32'd0);
    check("av_queue_drained", 32'(av_q.size()), 32'd0);
    check("pin_invariants", 32'(inv_bad), 32'd0);
    check("readdata_final", 32'(readdata), 32'(last_rdata));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
